// File: rtl/shift_pkg.sv
// shift_pkg: constants shared by the sequential shifter and its datapath step.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - shift direction encoding (DIR_LEFT / DIR_RIGHT)
package shift_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift of a WIDTH-bit word.
// Build option: SEQ_SHIFTER_ARITH_EN makes right shifts replicate the MSB
// (arithmetic); otherwise right shifts zero-fill.
// Ports:
//   data     in  WIDTH  word to shift
//   dir      in  1      DIR_LEFT / DIR_RIGHT
//   shifted  out WIDTH  word after a one-bit shift
//   bit_out  out 1      bit that fell off the end
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

`ifdef SEQ_SHIFTER_ARITH_EN
    // Sign bit is replicated so repeated steps floor toward minus infinity.
    logic fill_msb;
    assign fill_msb = data[WIDTH-1];
`else
    logic fill_msb;
    assign fill_msb = 1'b0;
`endif

    always_comb begin
        if (dir == DIR_LEFT) begin
            shifted = {data[WIDTH-2:0], 1'b0};
            bit_out = data[WIDTH-1];
        end else begin
            shifted = {fill_msb, data[WIDTH-1:1]};
            bit_out = data[0];
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-shift replacement, one bit per clock.
// A request is accepted in IDLE, shifted in SHIFT for in_amt cycles, and the
// registered result is held in DONE until the consumer takes it.
// Build option: SEQ_SHIFTER_ARITH_EN selects arithmetic right shift.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_data, in_amt, in_dir  operand, shift distance, direction (0=left)
//   out_valid/out_ready      result handshake
//   out_data, out_lost       result, set if any 1-bit was shifted out
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost
);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;
    logic             lost_q;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data    (data_q),
        .dir     (dir_q),
        .shifted (step_data),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_LEFT;
            lost_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        cnt_q  <= in_amt;
                        dir_q  <= in_dir;
                        lost_q <= 1'b0;
                        state  <= (in_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= step_data;
                    lost_q <= lost_q | step_bit;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    // Last step lands this edge, so the result is ready next cycle.
                    if (cnt_q == AMT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    // Returning to IDLE first keeps take and accept in separate cycles.
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_lost  = lost_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    localparam int WIDTH = 4;
    localparam int AMT_W = 2;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_lost;

    int n_cmp = 0;
    int n_err = 0;

    seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lost  (out_lost)
    );

    always #5 clk = ~clk;

    // Reference: arithmetic on integers, no step-by-step shifting.
    function automatic void model(input int d, input int amt, input bit dir,
                                  output int res, output bit lost);
        int v;
        if (!dir) begin
            v    = d * (1 << amt);
            res  = v & MASK;
            lost = (v >> WIDTH) != 0;
        end else begin
`ifdef SEQ_SHIFTER_ARITH_EN
            v   = (d >= (1 << (WIDTH - 1))) ? d - (1 << WIDTH) : d;
            res = int'($floor(real'(v) / real'(1 << amt))) & MASK;
`else
            res = d / (1 << amt);
`endif
            lost = (d % (1 << amt)) != 0;
        end
    endfunction

    // Drive one request, wait for its result (bounded), then take it.
    // lat counts cycles after the accepting edge until out_valid is seen.
    task automatic run_op(input int d, input int amt, input bit dir,
                          output int lat, output int od, output bit ol);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_amt   = AMT_W'(amt);
        in_dir   = dir;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        od = int'(out_data);
        ol = out_lost;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_lost} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b data=%b lost=%b, want 1 0 0000 0",
                     in_ready, out_valid, out_data, out_lost);
        end
    endtask

    task automatic test_vectors();
        int lat, od; bit ol;
        int exp_d; bit exp_l;
        int vd[3]  = '{4'b0011, 4'b1011, 4'b1100};
        int va[3]  = '{2, 3, 3};
        bit vdr[3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_op(vd[k], va[k], vdr[k], lat, od, ol);
            model(vd[k], va[k], vdr[k], exp_d, exp_l);
            n_cmp++;
            if (lat != va[k] + 1 || od != exp_d || ol !== exp_l) begin
                n_err++;
                $display("FAIL vector%0d: lat=%0d data=%0d lost=%b, want lat=%0d data=%0d lost=%b",
                         k, lat, od, ol, va[k] + 1, exp_d, exp_l);
            end
        end
    endtask

    task automatic test_hold();
        bit bad = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0101; in_amt = 2'd0; in_dir = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== 4'b0101 || out_lost !== 1'b0 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL hold: vld=%b data=%b rdy=%b, want 1 0101 0 for 5 cycles",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_take: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst_mid();
        bit seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0111; in_amt = 2'd3; in_dir = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_lost} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid: rdy=%b vld=%b data=%b lost=%b, want 1 0 0000 0",
                     in_ready, out_valid, out_data, out_lost);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_mid_result: out_valid=1 seen, want no result");
        end
    endtask

    task automatic test_sweep();
        int lat, od; bit ol;
        int exp_d; bit exp_l;
        for (int d = 0; d < 16; d += 4)
            for (int a = 0; a < 4; a++)
                for (int dr = 0; dr < 2; dr++) begin
                    run_op(d, a, bit'(dr), lat, od, ol);
                    model(d, a, bit'(dr), exp_d, exp_l);
                    n_cmp++;
                    if (lat != a + 1 || od != exp_d || ol !== exp_l) begin
                        n_err++;
                        $display("FAIL sweep d=%0d a=%0d dir=%0d: lat=%0d data=%0d lost=%b, want %0d %0d %b",
                                 d, a, dr, lat, od, ol, a + 1, exp_d, exp_l);
                    end
                end
    endtask

    task automatic test_random();
        int lat, od; bit ol;
        int exp_d; bit exp_l;
        int d, a; bit dr;
        for (int k = 0; k < 40; k++) begin
            d  = int'($urandom_range(0, MASK));
            a  = int'($urandom_range(0, 3));
            dr = bit'($urandom_range(0, 1));
            run_op(d, a, dr, lat, od, ol);
            model(d, a, dr, exp_d, exp_l);
            n_cmp++;
            if (lat != a + 1 || od != exp_d || ol !== exp_l) begin
                n_err++;
                $display("FAIL random d=%0d a=%0d dir=%0d: lat=%0d data=%0d lost=%b, want %0d %0d %b",
                         d, a, dr, lat, od, ol, a + 1, exp_d, exp_l);
            end
        end
    endtask

    // in_valid held high with scrambled inputs: they must not disturb the
    // operation in flight, and no accept may coincide with the take.
    task automatic test_back_to_back();
        int exp_d; bit exp_l;
        int lat = 99;
        model(4'b1001, 1, 1'b0, exp_d, exp_l);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1001; in_amt = 2'd1; in_dir = 1'b0;
        @(posedge clk);
        #1 begin in_data = 4'b1111; in_amt = 2'd3; in_dir = 1'b1; end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        n_cmp++;
        if (lat != 2 || int'(out_data) != exp_d || out_lost !== exp_l) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d data=%0d lost=%b, want 2 %0d %b",
                     lat, out_data, out_lost, exp_d, exp_l);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_take: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        model(4'b1111, 3, 1'b1, exp_d, exp_l);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        n_cmp++;
        if (lat != 4 || int'(out_data) != exp_d || out_lost !== exp_l) begin
            n_err++;
            $display("FAIL b2b_second: lat=%0d data=%0d lost=%b, want 4 %0d %b",
                     lat, out_data, out_lost, exp_d, exp_l);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_rst_mid();
        test_sweep();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
